// File: rtl/cnn_pkg.sv
// Shared types and helpers for the streaming CNN layers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cnn_pkg;

    localparam int DATA_WIDTH = 24;

    typedef logic signed [DATA_WIDTH-1:0] pixel_t;

    function automatic pixel_t smax(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pixel_t relu(input pixel_t a);
        return a[DATA_WIDTH-1] ? '0 : a;
    endfunction

    // Width of a counter that runs 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Register-array line buffer: one write port, one combinational read port.
// Latency: write visible on the read port the cycle after wr_en.
// Backpressure: none; accepts a write every cycle.
module pool_line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int WIDTH = 24,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    // Contents are always written before they are read, so no reset.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/maxpool2x2_relu.sv
// Streaming 2x2 stride-2 max-pool with optional ReLU on a raster pixel stream.
// Latency: one cycle from the pixel completing a window to valid_out.
// Backpressure: none; one pixel per valid_in cycle, gaps simply hold state.
module maxpool2x2_relu #(
    parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int IMG_WIDTH  = 10,
    parameter int IMG_HEIGHT = 10,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         valid_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         valid_out,
    output logic                         frame_done
);

    import cnn_pkg::*;

    localparam int CW    = cnt_w(IMG_WIDTH);
    localparam int RW    = cnt_w(IMG_HEIGHT);
    localparam int DEPTH = IMG_WIDTH / 2;
    localparam int AW    = cnt_w(DEPTH);
    localparam bit ODD_W = (IMG_WIDTH % 2) != 0;
    localparam bit ODD_H = (IMG_HEIGHT % 2) != 0;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]                col;
    logic [RW-1:0]                row;
    logic signed [DATA_WIDTH-1:0] h_max;
    logic signed [DATA_WIDTH-1:0] lbuf_rd;
    logic signed [DATA_WIDTH-1:0] pair_max;
    logic signed [DATA_WIDTH-1:0] win_max;
    logic signed [DATA_WIDTH-1:0] pooled;
    logic [AW-1:0]                lbuf_addr;
    logic                         col_end;
    logic                         row_end;
    logic                         in_region;
    logic                         lbuf_wr;

    assign col_end   = (col == COL_LAST);
    assign row_end   = (row == ROW_LAST);
    // Only an odd trailing column/row falls outside the pairing region.
    assign in_region = !(ODD_W && col_end) && !(ODD_H && row_end);

    assign lbuf_addr = AW'(col >> 1);
    assign pair_max  = DATA_WIDTH'(smax(pixel_t'(h_max), pixel_t'(data_in)));
    assign win_max   = DATA_WIDTH'(smax(pixel_t'(lbuf_rd), pixel_t'(pair_max)));
    assign pooled    = RELU_EN ? DATA_WIDTH'(relu(pixel_t'(win_max))) : win_max;
    assign lbuf_wr   = valid_in && in_region && col[0] && !row[0];

    pool_line_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH),
        .AW    (AW)
    ) u_lbuf (
        .clk     (clk),
        .wr_en   (lbuf_wr),
        .wr_addr (lbuf_addr),
        .wr_dat  (pair_max),
        .rd_addr (lbuf_addr),
        .rd_dat  (lbuf_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            h_max      <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                frame_done <= col_end && row_end;
                if (in_region) begin
                    if (!col[0]) begin
                        h_max <= data_in;
                    end else if (row[0]) begin
                        data_out  <= pooled;
                        valid_out <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_relu.sv
// Scoreboard bench: three pooler instances (4x4 ReLU, 4x4 linear, 5x5 ReLU)
// driven with directed frames; a negedge monitor checks values, timing and hold.
module tb_maxpool2x2_relu;

    typedef struct {
        int v;
        int c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic signed [23:0] din  [3];
    logic               vin  [3];
    logic signed [23:0] dout [3];
    logic               vout [3];
    logic               fd   [3];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t qv [3][$];
    int   qf [3][$];
    int   n_push [3];
    int   n_seen [3];
    int   last_out [3];
    int   comp [4];
    int   expv [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maxpool2x2_relu #(.DATA_WIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(4), .RELU_EN(1'b1)) u_a (
        .clk(clk), .rst(rst), .data_in(din[0]), .valid_in(vin[0]),
        .data_out(dout[0]), .valid_out(vout[0]), .frame_done(fd[0]));

    maxpool2x2_relu #(.DATA_WIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(4), .RELU_EN(1'b0)) u_b (
        .clk(clk), .rst(rst), .data_in(din[1]), .valid_in(vin[1]),
        .data_out(dout[1]), .valid_out(vout[1]), .frame_done(fd[1]));

    maxpool2x2_relu #(.DATA_WIDTH(24), .IMG_WIDTH(5), .IMG_HEIGHT(5), .RELU_EN(1'b1)) u_c (
        .clk(clk), .rst(rst), .data_in(din[2]), .valid_in(vin[2]),
        .data_out(dout[2]), .valid_out(vout[2]), .frame_done(fd[2]));

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                chk("reset_valid_out", int'(vout[d]), 0);
                chk("reset_data_out", int'(dout[d]), 0);
                chk("reset_frame_done", int'(fd[d]), 0);
                last_out[d] = 0;
            end else begin
                if (vout[d]) begin
                    n_seen[d]++;
                    if (qv[d].size() == 0) begin
                        chk("unexpected_valid_out", 1, 0);
                    end else begin
                        exp_t e;
                        e = qv[d].pop_front();
                        chk("pool_value", int'(dout[d]), e.v);
                        chk("pool_cycle", cyc, e.c);
                    end
                    last_out[d] = int'(dout[d]);
                end else begin
                    chk("data_out_hold", int'(dout[d]), last_out[d]);
                end
                if (fd[d]) begin
                    if (qf[d].size() == 0) begin
                        chk("unexpected_frame_done", 1, 0);
                    end else begin
                        chk("frame_done_cycle", cyc, qf[d].pop_front());
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives npx pixels sgn*(base+i); pushes expectations for indices in comp[].
    task automatic send_frame(input int d, input int npx, input int base, input int sgn,
                              input bit gap, input bit full);
        for (int i = 0; i < npx; i++) begin
            din[d] = 24'(sgn * (base + i));
            vin[d] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (comp[k] == i) begin
                    exp_t e;
                    e.v = expv[k];
                    e.c = cyc + 1;
                    qv[d].push_back(e);
                    n_push[d]++;
                end
            end
            if (full && i == npx - 1) qf[d].push_back(cyc + 1);
            @(posedge clk);
            #1;
            vin[d] = 1'b0;
            if (gap) begin
                idle(1);
                if (i == 9) idle(int'($urandom_range(3, 7)));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            din[d] = '0;
            vin[d] = 1'b0;
            n_push[d] = 0;
            n_seen[d] = 0;
            last_out[d] = 0;
        end
        idle(3);
        rst = 1'b1;
        idle(2);

        // 4x4 ReLU: positive, negative, gapped and back-to-back frames
        comp = '{5, 7, 13, 15};
        expv = '{6, 8, 14, 16};
        send_frame(0, 16, 1, 1, 1'b0, 1'b1);
        idle(3);
        expv = '{0, 0, 0, 0};
        send_frame(0, 16, 1, -1, 1'b0, 1'b1);
        idle(3);
        expv = '{6, 8, 14, 16};
        send_frame(0, 16, 1, 1, 1'b1, 1'b1);
        idle(3);
        send_frame(0, 16, 1, 1, 1'b0, 1'b1);
        expv = '{106, 108, 114, 116};
        send_frame(0, 16, 101, 1, 1'b0, 1'b1);
        idle(3);

        // Abort after 7 pixels: the window closed by pixel 6 still emits,
        // the frame never completes, and the next frame restarts at (0,0).
        comp = '{5, -1, -1, -1};
        expv = '{6, 0, 0, 0};
        send_frame(0, 7, 1, 1, 1'b0, 1'b0);
        idle(2);
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(1);
        comp = '{5, 7, 13, 15};
        expv = '{6, 8, 14, 16};
        send_frame(0, 16, 1, 1, 1'b0, 1'b1);
        idle(3);

        // 4x4 without ReLU, negative frame
        expv = '{-1, -3, -9, -11};
        send_frame(1, 16, 1, -1, 1'b0, 1'b1);
        idle(3);

        // 5x5 ReLU: trailing column 4 and row 4 dropped
        comp = '{6, 8, 16, 18};
        expv = '{6, 8, 16, 18};
        send_frame(2, 25, 0, 1, 1'b0, 1'b1);

        for (int t = 0; t < 20; t++) begin
            if (qv[0].size() + qv[1].size() + qv[2].size() +
                qf[0].size() + qf[1].size() + qf[2].size() == 0) break;
            idle(1);
        end
        idle(2);
        for (int d = 0; d < 3; d++) begin
            chk("pending_outputs", qv[d].size(), 0);
            chk("pending_frame_done", qf[d].size(), 0);
            chk("valid_out_count", n_seen[d], n_push[d]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
